ccsds_tx_sequencer: RTL and testbench
=====================================

CCSDS_TX_SEQUENCER -- requirements
Module: ccsds_tx_sequencer

Interface
REQ-001 Parameter ASM_WORD, default 32'h1ACFFC1D, attached sync marker sent MSB-first before every frame.
REQ-002 Parameter FRAME_BYTES, default 223, payload bytes per frame; legal range 1..1023.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_i  input  1  synchronous reset, active-high.
REQ-005 enable_i  input  1  permits starting new frames.
REQ-006 cycles_per_bit  input  32  bit period minus one, in clk_i cycles (0 = one bit per cycle).
REQ-007 data_i  input  8  payload byte.
REQ-008 valid_i  input  1  data_i valid.
REQ-009 ready_o  output  1  byte buffer empty; a byte transfers when valid_i && ready_o.
REQ-010 bit_o  output  1  serial bit, held for the full bit period.
REQ-011 bit_strobe_o  output  1  one-cycle pulse in the first cycle of each bit period.
REQ-012 bit_payload_o  output  1  current bit is payload, to be randomized downstream.
REQ-013 scr_init_o  output  1  one-cycle pulse commanding the downstream randomizer to reload all-ones.
REQ-014 scr_adv_o  output  1  one-cycle pulse advancing the randomizer by one bit.
REQ-015 frame_start_o  output  1  one-cycle pulse with the first ASM bit strobe.
REQ-016 busy_o  output  1  state is not IDLE.
REQ-017 underrun_o  output  1  one-cycle pulse when a fill byte replaces missing data.

Function
REQ-018 States: IDLE, ASM, PAYLOAD; one-entry byte buffer plus 8-bit shift register.
REQ-019 Bit period is cycles_per_bit+1 cycles; a 32-bit cycle counter restarts at 0 on each bit strobe; a cycles_per_bit change takes effect at the next bit boundary.
REQ-020 IDLE -> ASM when enable_i=1 and the buffer is full; the first ASM bit strobe occurs the next cycle.
REQ-021 ASM emits 32 bits of ASM_WORD MSB-first with bit_payload_o=0; scr_adv_o stays 0.
REQ-022 scr_init_o and frame_start_o pulse together with the first ASM bit strobe.
REQ-023 After the 32nd ASM bit, the state becomes PAYLOAD; each payload byte is sent MSB-first with bit_payload_o=1 and scr_adv_o pulsing with every payload bit strobe.
REQ-024 At each payload byte boundary (first bit of byte), the shift register loads the buffer and the buffer is freed in the same cycle.
REQ-025 If the buffer is empty at a payload byte boundary, byte 8'h00 is sent instead and underrun_o pulses; the frame continues.
REQ-026 After FRAME_BYTES*8 payload bits, the sequencer starts ASM immediately (no gap) if enable_i=1 and the buffer is full or the idle-frame feature applies; otherwise it goes to IDLE.
REQ-027 Deasserting enable_i mid-frame does not truncate the frame; the current frame completes.
REQ-028 A byte accepted in the same cycle the buffer is freed is stored; ready_o depends only on registered buffer state.
REQ-029 In IDLE: bit_o=0, bit_strobe_o=0, bit_payload_o=0, and the counters hold at 0.

Reset
REQ-030 rst_i=1 for one clock forces IDLE; buffer empty; counters 0; all outputs 0 except ready_o=1 from the cycle after reset.
REQ-031 Reset mid-frame aborts the frame; the partial frame is not resumed and the buffered byte is discarded.

Configuration
REQ-032 Macro CCSDS_TX_SEQ_IDLE_FRAME_EN defined: in IDLE with enable_i=1 and an empty buffer, an idle frame starts (ASM plus FRAME_BYTES fill bytes 8'h00, underrun_o not pulsed); end-of-frame with an empty buffer also chains an idle frame.
REQ-033 Macro undefined: frames start only with a full buffer, and the sequencer stays silent in IDLE.

Verification
REQ-034 cycles_per_bit=0, FRAME_BYTES=2, enable_i=1, bytes A5,3C always ready -> 48 consecutive strobes: 1ACFFC1D, A5, 3C; scr_adv_o count 16, scr_init_o once.
REQ-035 cycles_per_bit=3 -> bit_strobe_o every 4 cycles; bit_o stable 4 cycles.
REQ-036 FRAME_BYTES=2, only A5 supplied -> second byte 00, one underrun_o pulse, then IDLE (macro off).
REQ-037 Continuous data, 3 frames -> ASM of each next frame directly follows the last payload bit; 3 scr_init_o pulses.
REQ-038 rst_i at payload bit 5 -> next cycle busy_o=0, outputs 0, ready_o=1; a new frame restarts with the ASM.
REQ-039 With the macro defined, enable_i=1 and no data -> repeated frames 1ACFFC1D + zeros; underrun_o never pulses.

Source files
------------

// File: rtl/ccsds_tx_sequencer.sv
// CCSDS transmit sequencer: sends the ASM followed by FRAME_BYTES payload bytes, bit-serial.
// Define CCSDS_TX_SEQ_IDLE_FRAME_EN to send all-zero idle frames whenever data is missing at frame start.
module ccsds_tx_sequencer #(
    parameter logic [31:0] ASM_WORD    = 32'h1ACFFC1D,
    parameter int          FRAME_BYTES = 223
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [31:0] cycles_per_bit,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        bit_o,
    output logic        bit_strobe_o,
    output logic        bit_payload_o,
    output logic        scr_init_o,
    output logic        scr_adv_o,
    output logic        frame_start_o,
    output logic        busy_o,
    output logic        underrun_o
);

`ifdef CCSDS_TX_SEQ_IDLE_FRAME_EN
    localparam logic IDLE_EN = 1'b1;
`else
    localparam logic IDLE_EN = 1'b0;
`endif

    localparam logic [9:0] LAST_BYTE = 10'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ASM, ST_PAYLOAD} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  shift_q, shift_d;
    logic        buf_full_q, buf_full_d;
    logic        idle_frame_q, idle_frame_d;

    logic        strobe, bit_end, byte_first, start_ok, accept, free_buf;
    logic [7:0]  load_byte;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        bit_idx_d    = bit_idx_q;
        byte_cnt_d   = byte_cnt_q;
        buf_d        = buf_q;
        shift_d      = shift_q;
        buf_full_d   = buf_full_q;
        idle_frame_d = idle_frame_q;

        strobe     = (state_q != ST_IDLE) && (cnt_q == 32'd0);
        // The period seen in a strobe cycle is the fresh input; it is then frozen for the rest of the bit.
        bit_end    = (state_q != ST_IDLE) && (cnt_q == (strobe ? cycles_per_bit : period_q));
        byte_first = strobe && (state_q == ST_PAYLOAD) && (bit_idx_q == 5'd0);
        start_ok   = enable_i && (buf_full_q || IDLE_EN);
        accept     = valid_i && !buf_full_q;
        free_buf   = byte_first && !idle_frame_q;
        load_byte  = (buf_full_q && !idle_frame_q) ? buf_q : 8'h00;

        if (strobe)
            period_d = cycles_per_bit;
        if (byte_first)
            shift_d = load_byte;

        if (accept) begin
            buf_d      = data_i;
            buf_full_d = 1'b1;
        end else if (free_buf) begin
            buf_full_d = 1'b0;
        end

        cnt_d = bit_end ? 32'd0 : cnt_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = 32'd0;
                bit_idx_d  = 5'd0;
                byte_cnt_d = 10'd0;
                if (start_ok) begin
                    state_d      = ST_ASM;
                    idle_frame_d = IDLE_EN && !buf_full_q;
                end
            end
            ST_ASM: begin
                if (bit_end) begin
                    if (bit_idx_q == 5'd31) begin
                        state_d    = ST_PAYLOAD;
                        bit_idx_d  = 5'd0;
                        byte_cnt_d = 10'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bit_end) begin
                    if (bit_idx_q == 5'd7) begin
                        bit_idx_d = 5'd0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = 10'd0;
                            if (start_ok) begin
                                state_d      = ST_ASM;
                                idle_frame_d = IDLE_EN && !buf_full_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 10'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            period_q     <= 32'd0;
            bit_idx_q    <= 5'd0;
            byte_cnt_q   <= 10'd0;
            buf_q        <= 8'h00;
            shift_q      <= 8'h00;
            buf_full_q   <= 1'b0;
            idle_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            bit_idx_q    <= bit_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            buf_q        <= buf_d;
            shift_q      <= shift_d;
            buf_full_q   <= buf_full_d;
            idle_frame_q <= idle_frame_d;
        end
    end

    always_comb begin
        bit_o = 1'b0;
        case (state_q)
            ST_ASM:     bit_o = ASM_WORD[5'd31 - bit_idx_q];
            // The first bit of a byte comes straight from the byte being loaded this cycle.
            ST_PAYLOAD: bit_o = byte_first ? load_byte[7] : shift_q[3'd7 - bit_idx_q[2:0]];
            default:    bit_o = 1'b0;
        endcase
    end

    assign ready_o       = !buf_full_q;
    assign bit_strobe_o  = strobe;
    assign bit_payload_o = (state_q == ST_PAYLOAD);
    assign scr_init_o    = strobe && (state_q == ST_ASM) && (bit_idx_q == 5'd0);
    assign frame_start_o = scr_init_o;
    assign scr_adv_o     = strobe && (state_q == ST_PAYLOAD);
    assign busy_o        = (state_q != ST_IDLE);
    assign underrun_o    = byte_first && !buf_full_q && !idle_frame_q;

endmodule

// File: tb/tb_ccsds_tx_sequencer.sv
// Scoreboard bench for ccsds_tx_sequencer with FRAME_BYTES=2: expected bits are queued per frame
// and compared at every bit strobe; bit hold, strobe spacing and pulse counts are checked as well.
module tb_ccsds_tx_sequencer;

    localparam logic [31:0] ASM = 32'h1ACFFC1D;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [31:0] cycles_per_bit;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o, bit_o, bit_strobe_o, bit_payload_o;
    logic        scr_init_o, scr_adv_o, frame_start_o, busy_o, underrun_o;

    ccsds_tx_sequencer #(.ASM_WORD(ASM), .FRAME_BYTES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .cycles_per_bit(cycles_per_bit),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .bit_o(bit_o),
        .bit_strobe_o(bit_strobe_o), .bit_payload_o(bit_payload_o), .scr_init_o(scr_init_o),
        .scr_adv_o(scr_adv_o), .frame_start_o(frame_start_o), .busy_o(busy_o),
        .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe, n_init, n_adv, n_und;
    int exp_period = 1;
    int gap = 0;
    bit have_prev = 0;
    bit mon_en = 0;
    logic last_bit = 1'b0;
    logic [1:0] exp_q[$];
    logic [7:0] tx_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] pay;
        pay = {b0, b1};
        for (int i = 31; i >= 0; i--) exp_q.push_back({1'b0, ASM[i]});
        for (int i = 15; i >= 0; i--) exp_q.push_back({1'b1, pay[i]});
    endtask

    task automatic clear_counts();
        n_strobe = 0; n_init = 0; n_adv = 0; n_und = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !busy_o && tx_q.size() == 0) break;
        end
        check_eq("all_bits_sent", exp_q.size(), 0);
        check_eq("back_to_idle", busy_o, 0);
    endtask

    // Byte source: presents the queue head; the take is confirmed at the next falling edge.
    initial begin
        bit take_pend;
        take_pend = 0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        forever begin
            @(negedge clk_i);
            if (take_pend && tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_q.size() > 0 && !rst_i) begin
                valid_i   = 1'b1;
                data_i    = tx_q[0];
                take_pend = ready_o;
            end else begin
                valid_i   = 1'b0;
                take_pend = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (mon_en) begin
            check_eq("init_eq_fs", scr_init_o, frame_start_o);
            check_eq("adv_eq_pstrobe", scr_adv_o, bit_strobe_o & bit_payload_o);
            if (bit_strobe_o) begin
                n_strobe++;
                check_eq("strobe_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check_eq("bit", bit_o, e[0]);
                    check_eq("payload_flag", bit_payload_o, e[1]);
                end
                if (have_prev) check_eq("strobe_period", gap + 1, exp_period);
                have_prev = 1;
                gap = 0;
                last_bit = bit_o;
            end else if (busy_o) begin
                gap++;
                check_eq("bit_hold", bit_o, last_bit);
            end else begin
                have_prev = 0;
            end
            if (scr_init_o) n_init++;
            if (scr_adv_o) n_adv++;
            if (underrun_o) n_und++;
        end
    end

    initial begin
        int pcount;
        rst_i = 1'b1;
        enable_i = 1'b0;
        cycles_per_bit = 32'd0;
        clear_counts();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_bit", bit_o, 0);
        check_eq("rst_strobe", bit_strobe_o, 0);
        check_eq("rst_outs", {bit_payload_o, scr_init_o, scr_adv_o, frame_start_o, underrun_o}, 0);
        mon_en = 1;

`ifdef CCSDS_TX_SEQ_IDLE_FRAME_EN
        // Idle frames: no data at all, enable held
        clear_counts();
        push_frame(8'h00, 8'h00);
        push_frame(8'h00, 8'h00);
        enable_i = 1'b1;
        for (int c = 0; c < 400 && exp_q.size() > 16; c++) @(negedge clk_i);
        enable_i = 1'b0;
        wait_done(400);
        check_eq("idle_inits", n_init, 2);
        check_eq("idle_underruns", n_und, 0);
        $display("[TB] idle frames: strobes=%0d", n_strobe);
`else
        // Two-byte frame at one bit per cycle
        clear_counts();
        exp_period = 1;
        push_frame(8'hA5, 8'h3C);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        enable_i = 1'b1;
        wait_done(400);
        enable_i = 1'b0;
        check_eq("f1_strobes", n_strobe, 48);
        check_eq("f1_inits", n_init, 1);
        check_eq("f1_advs", n_adv, 16);
        check_eq("f1_underruns", n_und, 0);
        $display("[TB] frame A5 3C cpb=0: strobes=%0d adv=%0d", n_strobe, n_adv);

        // Four-cycle bit period
        clear_counts();
        cycles_per_bit = 32'd3;
        exp_period = 4;
        push_frame(8'h96, 8'h0F);
        tx_q.push_back(8'h96);
        tx_q.push_back(8'h0F);
        enable_i = 1'b1;
        wait_done(1000);
        enable_i = 1'b0;
        check_eq("f2_strobes", n_strobe, 48);
        check_eq("f2_advs", n_adv, 16);
        $display("[TB] frame 96 0F cpb=3: strobes=%0d", n_strobe);

        // Underrun: only one byte supplied
        clear_counts();
        cycles_per_bit = 32'd0;
        exp_period = 1;
        push_frame(8'hA5, 8'h00);
        tx_q.push_back(8'hA5);
        enable_i = 1'b1;
        wait_done(400);
        repeat (20) @(negedge clk_i);
        check_eq("ur_stays_idle", busy_o, 0);
        enable_i = 1'b0;
        check_eq("ur_underruns", n_und, 1);
        check_eq("ur_inits", n_init, 1);
        check_eq("ur_strobes", n_strobe, 48);
        $display("[TB] underrun frame: underruns=%0d", n_und);

        // Three back-to-back frames
        clear_counts();
        push_frame(8'h11, 8'h22);
        push_frame(8'hF0, 8'h81);
        push_frame(8'h7E, 8'hC3);
        foreach (tx_q[i]) ;
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        tx_q.push_back(8'hF0); tx_q.push_back(8'h81);
        tx_q.push_back(8'h7E); tx_q.push_back(8'hC3);
        enable_i = 1'b1;
        wait_done(1000);
        enable_i = 1'b0;
        check_eq("chain_inits", n_init, 3);
        check_eq("chain_strobes", n_strobe, 144);
        check_eq("chain_advs", n_adv, 48);
        $display("[TB] chained frames: inits=%0d strobes=%0d", n_init, n_strobe);

        // Reset at payload bit 5, then a fresh frame
        clear_counts();
        push_frame(8'hA5, 8'h3C);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        enable_i = 1'b1;
        pcount = 0;
        for (int c = 0; c < 400 && pcount < 6; c++) begin
            @(negedge clk_i);
            if (bit_strobe_o && bit_payload_o) pcount++;
        end
        check_eq("rr_reached_bit5", pcount, 6);
        rst_i = 1'b1;
        mon_en = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        tx_q.delete();
        check_eq("rr_busy", busy_o, 0);
        check_eq("rr_ready", ready_o, 1);
        check_eq("rr_bit", bit_o, 0);
        check_eq("rr_outs", {bit_strobe_o, bit_payload_o, scr_init_o, scr_adv_o, underrun_o}, 0);
        @(negedge clk_i);
        check_eq("rr_no_resume", busy_o, 0);
        mon_en = 1;
        clear_counts();
        push_frame(8'h5A, 8'hC3);
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hC3);
        wait_done(400);
        enable_i = 1'b0;
        check_eq("rr_inits", n_init, 1);
        check_eq("rr_strobes", n_strobe, 48);
        $display("[TB] reset mid-frame then restart: strobes=%0d", n_strobe);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
